// File: rtl/step_pulse_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : step_pulse_gen_pkg
// Description : Shared state encoding and default timing for the step pulse
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
package step_pulse_gen_pkg;

    localparam int unsigned c_DB_CYCLES_DEFAULT     = 8;
    localparam int unsigned c_HOLD_CYCLES_DEFAULT   = 64;
    localparam int unsigned c_REPEAT_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/step_pulse_gen_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Single-bit two-flop synchronizer, async active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
    input  logic clk,
    input  logic rstb,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : step_pulse_gen
// Description : Debounced push-button to single-cycle step pulse, with
//               optional hold-to-auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module step_pulse_gen
    import step_pulse_gen_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = c_DB_CYCLES_DEFAULT,
    parameter int unsigned HOLD_CYCLES   = c_HOLD_CYCLES_DEFAULT,
    parameter int unsigned REPEAT_CYCLES = c_REPEAT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rstb,
    input  logic btn_in,
    input  logic repeat_en,
    output logic step,
    output logic pressed
);

    localparam int unsigned c_DB_W   = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned c_TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned c_TMR_W  = (c_TMR_MAX > 2) ? $clog2(c_TMR_MAX) : 1;

    localparam logic [c_DB_W-1:0]  c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_HOLD_LAST = c_TMR_W'(HOLD_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_REP_LAST  = c_TMR_W'(REPEAT_CYCLES - 1);

    logic               btn_s;
    state_e             state_q,     state_d;
    logic [c_DB_W-1:0]  db_cnt_q,    db_cnt_d;
    logic [c_TMR_W-1:0] tmr_q,       tmr_d;
    logic               rep_phase_q, rep_phase_d;
    logic               step_q,      step_d;
    logic [c_TMR_W-1:0] w_tmr_last;

    sync2 u_sync2 (
        .clk  (clk),
        .rstb (rstb),
        .d_i  (btn_in),
        .q_o  (btn_s)
    );

    // First repeat waits HOLD_CYCLES; later ones use the shorter REPEAT_CYCLES.
    assign w_tmr_last = rep_phase_q ? c_REP_LAST : c_HOLD_LAST;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            tmr_q       <= '0;
            rep_phase_q <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            tmr_q       <= tmr_d;
            rep_phase_q <= rep_phase_d;
            step_q      <= step_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        tmr_d       = tmr_q;
        rep_phase_d = rep_phase_q;
        step_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d  = ST_PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            ST_PRESS_DB: begin
                if (!btn_s) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == c_DB_LAST) begin
                    state_d     = ST_HELD;
                    db_cnt_d    = '0;
                    tmr_d       = '0;
                    rep_phase_d = 1'b0;
                    step_d      = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + c_DB_W'(1);
                end
            end
            ST_HELD: begin
                // Release wins over a repeat step falling due on the same edge.
                if (!btn_s) begin
                    state_d     = ST_REL_DB;
                    db_cnt_d    = '0;
                    tmr_d       = '0;
                    rep_phase_d = 1'b0;
                end else if (!repeat_en) begin
                    tmr_d       = '0;
                    rep_phase_d = 1'b0;
                end else if (tmr_q == w_tmr_last) begin
                    tmr_d       = '0;
                    rep_phase_d = 1'b1;
                    step_d      = 1'b1;
                end else begin
                    tmr_d = tmr_q + c_TMR_W'(1);
                end
            end
            ST_REL_DB: begin
                if (btn_s) begin
                    state_d     = ST_HELD;
                    db_cnt_d    = '0;
                    tmr_d       = '0;
                    rep_phase_d = 1'b0;
                end else if (db_cnt_q == c_DB_LAST) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + c_DB_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign step    = step_q;
    assign pressed = (state_q == ST_HELD) || (state_q == ST_REL_DB);

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_step_pulse_gen
// Description : Directed self-checking bench for step_pulse_gen (defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_pulse_gen;

    logic clk = 1'b0;
    logic rstb;
    logic btn_in;
    logic repeat_en;
    logic step;
    logic pressed;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int b2b      = 0;
    logic prev_step = 1'b0;
    int step_log[$];
    int exp_log[$];
    int c0, r0, s0, g0, t0, t, plow;
    int bl_lvl[6] = '{1, 0, 1, 0, 1, 0};
    int bl_len[6] = '{3, 2, 5, 1, 7, 4};

    step_pulse_gen #(
        .DB_CYCLES     (8),
        .HOLD_CYCLES   (64),
        .REPEAT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .btn_in    (btn_in),
        .repeat_en (repeat_en),
        .step      (step),
        .pressed   (pressed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Each logged entry is the index of the rising edge that raised step.
    always @(negedge clk) begin
        if (step === 1'b1) begin
            step_log.push_back(cyc);
            if (prev_step) b2b <= b2b + 1;
        end
        prev_step <= (step === 1'b1);
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pressed(input logic lvl, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pressed === lvl) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        step_log.delete();
        exp_log.delete();
    endtask

    task automatic compare_log(input string tag);
        check_eq({tag, "_count"}, step_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            check_eq($sformatf("%s_step%0d", tag, i),
                     (i < step_log.size()) ? step_log[i] : -1, exp_log[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstb      = 1'b1;
        btn_in    = 1'b0;
        repeat_en = 1'b0;
        #1 rstb = 1'b0;
        #2;
        check_eq("rst_step",    step,    0);
        check_eq("rst_pressed", pressed, 0);
        tick(3);
        rstb = 1'b1;
        tick(3);

        // A: clean press, 30 cycles, no repeat
        clear_logs();
        c0 = cyc;
        btn_in = 1'b1;
        wait_pressed(1'b1, 20, t);
        check_eq("A_press_latency", t, c0 + 11);
        tick(19);
        r0 = cyc;
        btn_in = 1'b0;
        wait_pressed(1'b0, 20, t);
        check_eq("A_release_latency", t, r0 + 11);
        tick(5);
        exp_log.push_back(c0 + 11);
        compare_log("A");

        // B: bounce burst then stable press
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            btn_in = bl_lvl[i][0];
            tick(bl_len[i]);
        end
        c0 = cyc;
        btn_in = 1'b1;
        tick(25);
        btn_in = 1'b0;
        tick(20);
        check_eq("B_pressed_after", pressed, 0);
        exp_log.push_back(c0 + 11);
        compare_log("B");

        // C: auto-repeat, released 150 cycles after the initial step
        repeat_en = 1'b1;
        clear_logs();
        c0 = cyc;
        btn_in = 1'b1;
        tick(161);
        btn_in = 1'b0;
        tick(20);
        exp_log = '{c0 + 11, c0 + 75, c0 + 91, c0 + 107, c0 + 123, c0 + 139, c0 + 155};
        compare_log("C");

        // D: 3-cycle release glitch while held
        clear_logs();
        c0 = cyc;
        s0 = c0 + 11;
        btn_in = 1'b1;
        tick(31);
        g0 = cyc;
        btn_in = 1'b0;
        plow = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) btn_in = 1'b1;
            if (pressed !== 1'b1) plow++;
        end
        check_eq("D_pressed_low_cycles", plow, 0);
        tick(63);
        btn_in = 1'b0;
        tick(20);
        exp_log = '{s0, g0 + 70};
        compare_log("D");

        // E: reset 5 cycles after the initial step, button still held
        repeat_en = 1'b0;
        clear_logs();
        c0 = cyc;
        s0 = c0 + 11;
        btn_in = 1'b1;
        tick(16);
        rstb = 1'b0;
        #1;
        check_eq("E_rst_step",    step,    0);
        check_eq("E_rst_pressed", pressed, 0);
        tick(2);
        t0 = cyc;
        rstb = 1'b1;
        tick(20);
        check_eq("E_repressed", pressed, 1);
        btn_in = 1'b0;
        tick(20);
        exp_log = '{s0, t0 + 11};
        compare_log("E");

        // F: release lands on the edge a repeat step is due
        repeat_en = 1'b1;
        clear_logs();
        c0 = cyc;
        s0 = c0 + 11;
        btn_in = 1'b1;
        tick(72);
        btn_in = 1'b0;
        tick(20);
        exp_log.push_back(s0);
        compare_log("F");

        // G: repeat disabled while held, then enabled restarts the hold delay
        repeat_en = 1'b0;
        clear_logs();
        c0 = cyc;
        s0 = c0 + 11;
        btn_in = 1'b1;
        tick(111);
        repeat_en = 1'b1;
        tick(70);
        btn_in = 1'b0;
        tick(20);
        repeat_en = 1'b0;
        exp_log = '{s0, s0 + 164};
        compare_log("G");

        check_eq("no_back_to_back", b2b, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 Parameter DB_CYCLES, 8, consecutive stable synchronized samples needed to accept a press or a release (minimum 2).
REQ-002 Parameter HOLD_CYCLES, 64, cycles between the initial step and the first auto-repeat step (minimum 2).
REQ-003 Parameter REPEAT_CYCLES, 16, cycles between consecutive auto-repeat steps (minimum 2).
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rstb  input  1  reset, asynchronous, active-low.
REQ-006 btn_in  input  1  raw, bouncy, asynchronous push-button level; 1 = pressed.
REQ-007 repeat_en  input  1  synchronous level; 1 = auto-repeat enabled while the button is held.
REQ-008 step  output  1  single-cycle count-enable pulse for the downstream counter's count-enable input.
REQ-009 pressed  output  1  debounced button level.

Function
REQ-010 btn_in SHALL pass through a 2-flop synchronizer; only its output btn_s is used by the FSM.
REQ-011 FSM states SHALL be IDLE, PRESS_DB, HELD and REL_DB, with one shared debounce counter sized to ceil(log2(DB_CYCLES)).
REQ-012 IDLE: btn_s=1 -> PRESS_DB with the debounce counter cleared to 0; otherwise remain.
REQ-013 PRESS_DB: btn_s=0 -> IDLE with no step (bounce rejected); btn_s=1 with counter=DB_CYCLES-1 -> HELD; otherwise increment the counter.
REQ-014 step SHALL be 1 for exactly the first cycle in HELD after a transition from PRESS_DB.
REQ-015 Latency: with btn_in rising before rising edge 1 and stable thereafter, step SHALL be high in the cycle following edge DB_CYCLES+3 (edge 11 for default parameters).
REQ-016 HELD: a repeat timer SHALL restart at entry; with repeat_en=1, step pulses HOLD_CYCLES cycles after the initial step, then every REPEAT_CYCLES cycles while held.
REQ-017 With repeat_en=0, no repeat steps SHALL be produced and the repeat timer SHALL be held at its restart value; setting repeat_en back to 1 restarts the HOLD_CYCLES delay.
REQ-018 HELD: btn_s=0 -> REL_DB with the debounce counter cleared; this transition takes priority over a repeat step due in the same cycle, so no step is produced.
REQ-019 REL_DB: btn_s=1 -> HELD with no step and the repeat timer restarted; btn_s=0 with counter=DB_CYCLES-1 -> IDLE; otherwise increment the counter.
REQ-020 pressed SHALL be 1 in HELD and REL_DB and 0 in IDLE and PRESS_DB.
REQ-021 step SHALL never be high in two consecutive cycles, and SHALL be registered with no combinational path from any input.
REQ-022 Counter and timer wrap-around SHALL NOT occur; every counter is cleared on each state transition that uses it.

Reset
REQ-023 rstb=0 SHALL immediately force the FSM to IDLE, set step=0 and pressed=0, and clear the synchronizer flops, debounce counter and repeat timer, regardless of clk.
REQ-024 Reset asserted mid-press SHALL discard the press; after release of reset, a still-pressed button SHALL be re-debounced from IDLE and SHALL produce a fresh initial step.
REQ-025 Reset deassertion SHALL be synchronized to clk at the system level; the block itself SHALL tolerate deassertion at any point without producing a spurious step.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding constants and the default DB_CYCLES, HOLD_CYCLES and REPEAT_CYCLES values.
REQ-027 The synchronizer SHALL be a separate sub-module, sync2 (1-bit, 2 flops, async active-low reset to 0), reusable by other input blocks.
REQ-028 The debounce FSM, counters and step generation SHALL reside in step_pulse_gen itself; the implementation is within 120-400 lines.

Verification
REQ-029 Clean press held 30 cycles then released, repeat_en=0, defaults -> exactly one step, in the cycle after edge 11; pressed rises with step and falls DB_CYCLES+3 cycles after btn_in falls.
REQ-030 Bounce burst of 0/1 toggles, each shorter than 8 cycles, before a stable press -> no step during the burst and exactly one step after the final stable level is accepted.
REQ-031 Press held 150 cycles, repeat_en=1 -> steps at relative cycles 0, 64, 80, 96, 112, 128, 144 (7 total), then none after release.
REQ-032 Release glitch of 3 cycles while in HELD -> no step, pressed stays 1, and the repeat timer restarts (next repeat 64 cycles after the glitch ends).
REQ-033 rstb asserted 5 cycles after the initial step with the button still held -> step=0 and pressed=0 immediately; after release of reset, one new step DB_CYCLES+3 edges later.
REQ-034 Release coinciding with a due repeat step -> no step in that cycle; a checker confirms step is never high for 2 consecutive cycles across all scenarios.
